// File: rtl/zy_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package zy_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

    localparam int         MD_CNT_W = 4;
    localparam logic [4:0] REG_X0   = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational decode of load-use hazards and EX-resolved control redirects.
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_regw,
    input  logic       ex_memr,
    input  logic       ex_br_taken,
    input  logic       ex_jump,
    output logic       load_use,
    output logic       redir
);
    import zy_pkg::*;

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
        // x0 reads are constant zero, so a load targeting x0 never stalls
        load_use = ex_memr && ex_regw && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
        redir    = ex_br_taken || ex_jump;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, mul/div, dmem wait.
// Optional performance counters are enabled with the PIPE_HAZARD_PERF_EN macro.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   RUN     | normal flow; redirect, md start and load-use evaluated
//   MD_WAIT | mul/div occupying EX; md_cnt counts down to completion
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_regw,
    input  logic            ex_memr,
    input  logic            ex_br_taken,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_md_start,
    input  logic            dmem_wait,
    output logic            pc_hold,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            ifid_hold,
    output logic            ifid_flush,
    output logic            idex_hold,
    output logic            idex_flush,
    output logic            exmem_hold,
    output logic            exmem_flush,
    output logic            md_busy,
    output logic            md_done
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_md_cnt
`endif
);
    import zy_pkg::*;

    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);
    localparam logic [MD_CNT_W-1:0] MD_ONE  = MD_CNT_W'(1);

    hz_state_t           state;
    logic [MD_CNT_W-1:0] md_cnt;
    logic                load_use;
    logic                redir;
    logic                md_last;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_regw     (ex_regw),
        .ex_memr     (ex_memr),
        .ex_br_taken (ex_br_taken),
        .ex_jump     (ex_jump),
        .load_use    (load_use),
        .redir       (redir)
    );

    // Treating 0 as "last" keeps a corrupted count from locking the FSM in MD_WAIT
    assign md_last = (md_cnt <= MD_ONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= RUN;
            md_cnt <= '0;
        end else if (!dmem_wait) begin
            case (state)
                RUN: begin
                    if (!redir && ex_md_start) begin
                        state  <= MD_WAIT;
                        md_cnt <= MD_LOAD;
                    end
                end
                MD_WAIT: begin
                    if (md_last) begin
                        state  <= RUN;
                        md_cnt <= '0;
                    end else begin
                        md_cnt <= md_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_hold     = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_hold   = 1'b0;
        idex_flush  = 1'b0;
        exmem_hold  = 1'b0;
        exmem_flush = 1'b0;
        md_done     = 1'b0;
        md_busy     = (state == MD_WAIT);

        if (dmem_wait) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
        end else if (state == MD_WAIT) begin
            // Bubble EX/MEM until the result is ready, then let it capture
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            md_done     = md_last;
            exmem_flush = !md_last;
        end else if (redir) begin
            pc_redirect = 1'b1;
            pc_target   = ex_target;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (ex_md_start) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
            perf_md_cnt    <= '0;
        end else begin
            if (pc_hold)     perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (pc_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (md_done)     perf_md_cnt    <= perf_md_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl (MD_LATENCY = 4).
module tb_pipe_hazard_ctrl;

    localparam int XLEN = 32;

    // Control bit order: pc_hold pc_redirect ifid_hold ifid_flush idex_hold idex_flush
    //                    exmem_hold exmem_flush md_busy md_done
    localparam logic [9:0] C_NONE  = 10'b0000_0000_00;
    localparam logic [9:0] C_LU    = 10'b1010_0100_00;
    localparam logic [9:0] C_RED   = 10'b0101_0100_00;
    localparam logic [9:0] C_DW    = 10'b1010_1010_00;
    localparam logic [9:0] C_START = 10'b1010_1001_00;
    localparam logic [9:0] C_MDW   = 10'b1010_1001_10;
    localparam logic [9:0] C_DONE  = 10'b1010_1000_11;
    localparam logic [9:0] C_DWMD  = 10'b1010_1010_10;

    logic            clk;
    logic            rstn;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_regw, ex_memr;
    logic            ex_br_taken, ex_jump, ex_md_start, dmem_wait;
    logic [XLEN-1:0] ex_target;
    logic            pc_hold, pc_redirect, ifid_hold, ifid_flush;
    logic            idex_hold, idex_flush, exmem_hold, exmem_flush;
    logic            md_busy, md_done;
    logic [XLEN-1:0] pc_target;
    logic [9:0]      ctl;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0]     perf_stall_cyc, perf_flush_cnt, perf_md_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use1;
        logic        use2;
        logic        regw;
        logic        memr;
        logic        br;
        logic        jump;
        logic        md_start;
        logic        dwait;
        logic [31:0] tgt_in;
        logic [9:0]  exp_ctl;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[12];

    pipe_hazard_ctrl #(.MD_LATENCY(4), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_regw     (ex_regw),
        .ex_memr     (ex_memr),
        .ex_br_taken (ex_br_taken),
        .ex_jump     (ex_jump),
        .ex_target   (ex_target),
        .ex_md_start (ex_md_start),
        .dmem_wait   (dmem_wait),
        .pc_hold     (pc_hold),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .ifid_hold   (ifid_hold),
        .ifid_flush  (ifid_flush),
        .idex_hold   (idex_hold),
        .idex_flush  (idex_flush),
        .exmem_hold  (exmem_hold),
        .exmem_flush (exmem_flush),
        .md_busy     (md_busy),
        .md_done     (md_done)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_md_cnt    (perf_md_cnt)
`endif
    );

    assign ctl = {pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_hold, idex_flush,
                  exmem_hold, exmem_flush, md_busy, md_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_ctl(input string nm, input logic [9:0] exp);
        n_chk++;
        if (ctl !== exp) begin
            n_fail++;
            $display("FAIL %s: ctl got %b expected %b", nm, ctl, exp);
        end
    endtask

    task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_regw = 1'b0; ex_memr = 1'b0;
        ex_br_taken = 1'b0; ex_jump = 1'b0; ex_md_start = 1'b0; dmem_wait = 1'b0;
        ex_target = '0;
    endtask

    task automatic set_lu();
        ex_memr = 1'b1; ex_regw = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        id_use_rs1 = v.use1; id_use_rs2 = v.use2; ex_regw = v.regw; ex_memr = v.memr;
        ex_br_taken = v.br; ex_jump = v.jump; ex_md_start = v.md_start; dmem_wait = v.dwait;
        ex_target = v.tgt_in;
    endtask

    initial begin
        //          rs1   rs2   rd    u1 u2 rw mr br jp md dw  tgt_in         exp_ctl  exp_tgt
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         C_NONE, 32'h0};
        vecs[1]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         C_LU,   32'h0};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         C_NONE, 32'h0};
        vecs[3]  = '{5'd7, 5'd0, 5'd7, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0,         C_LU,   32'h0};
        vecs[4]  = '{5'd7, 5'd3, 5'd7, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         C_NONE, 32'h0};
        vecs[5]  = '{5'd0, 5'd5, 5'd5, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0,         C_NONE, 32'h0};
        vecs[6]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         C_NONE, 32'h0};
        vecs[7]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 1, 0, 0, 0, 32'h0000_0100, C_RED,  32'h0000_0100};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEAD_BEEC, C_RED,  32'hDEAD_BEEC};
        vecs[9]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 1, 0, 0, 1, 32'h0000_0100, C_DW,   32'h0};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0,         C_DW,   32'h0};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0000_0040, C_RED,  32'h0000_0040};

        idle();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_ctl("reset_ctl", C_NONE);
        chk_val("reset_tgt", pc_target, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

`ifdef PIPE_HAZARD_PERF_EN
        @(negedge clk); idle(); ex_br_taken = 1'b1; ex_target = 32'h100;
        @(negedge clk); idle(); set_lu();
        @(negedge clk); idle(); ex_md_start = 1'b1;
        @(negedge clk); idle();
        repeat (3) @(negedge clk);
        #1;
        chk_val("perf_flush_cnt", perf_flush_cnt, 32'd1);
        chk_val("perf_md_cnt", perf_md_cnt, 32'd1);
        chk_val("perf_stall_cyc", perf_stall_cyc, 32'd5);
`endif

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk_ctl($sformatf("vec%0d_ctl", i), vecs[i].exp_ctl);
            chk_val($sformatf("vec%0d_tgt", i), pc_target, vecs[i].exp_tgt);
        end

        // Mul/div, no interference; load-use re-evaluated right after completion
        @(negedge clk); idle(); ex_md_start = 1'b1; #1; chk_ctl("md_start", C_START);
        @(negedge clk); idle(); #1; chk_ctl("md_wait3", C_MDW);
        @(negedge clk); #1; chk_ctl("md_wait2", C_MDW);
        @(negedge clk); set_lu(); #1; chk_ctl("md_done", C_DONE);
        @(negedge clk); #1; chk_ctl("md_exit_lu", C_LU);
        @(negedge clk); idle(); #1; chk_ctl("md_after", C_NONE);

        // dmem_wait for two cycles at md_cnt = 2 delays md_done by two cycles
        @(negedge clk); idle(); ex_md_start = 1'b1; #1; chk_ctl("dw_start", C_START);
        @(negedge clk); idle(); #1; chk_ctl("dw_cnt3", C_MDW);
        @(negedge clk); dmem_wait = 1'b1; #1; chk_ctl("dw_frz1", C_DWMD);
        @(negedge clk); #1; chk_ctl("dw_frz2", C_DWMD);
        @(negedge clk); dmem_wait = 1'b0; #1; chk_ctl("dw_cnt2", C_MDW);
        @(negedge clk); #1; chk_ctl("dw_done", C_DONE);
        @(negedge clk); #1; chk_ctl("dw_after", C_NONE);

        // Reset in the middle of MD_WAIT
        @(negedge clk); idle(); ex_md_start = 1'b1;
        @(negedge clk); idle(); #1; chk_ctl("rst_pre", C_MDW);
        #2; rstn = 1'b0;
        #1; chk_ctl("rst_mid", C_NONE);
        @(negedge clk); rstn = 1'b1; #1; chk_ctl("rst_rel", C_NONE);
        @(negedge clk); set_lu(); #1; chk_ctl("rst_run_lu", C_LU);
        @(negedge clk); idle(); #1; chk_ctl("rst_idle", C_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
